// File: rtl/snn_pkg.sv
// Shared constants and helpers for the spiking front-end: intensity width,
// LFSR geometry and the spike encoder state encoding.
package snn_pkg;

    localparam int WIDTH_P = 8;

    localparam int LFSR_W = 8;
    // Feedback taps for x^8+x^6+x^5+x^4+1 in a shift-left Fibonacci LFSR
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 8'b1011_1000;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 8'hA5;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } enc_state_e;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] k);
        logic [15:0] d;
        d = {v, v} << k;
        return d[15:8];
    endfunction

endpackage

// File: rtl/lfsr_prng.sv
// Fibonacci LFSR pseudo-random source with synchronous seed load and step enable.
// Load has priority over enable; the register never enters the all-zero state from a nonzero seed.
module lfsr_prng
    import snn_pkg::*;
#(
    parameter int             W         = LFSR_W,
    parameter logic [W-1:0]   TAPS      = LFSR_TAPS,
    parameter logic [W-1:0]   RESET_VAL = LFSR_SEED_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] seed_i,
    input  logic         en_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] value_r;
    logic [W-1:0] value_nxt_s;

    // Next-value selection: reload, advance or hold
    always_comb begin
        value_nxt_s = value_r;
        if (load_i) begin
            value_nxt_s = seed_i;
        end else if (en_i) begin
            value_nxt_s = {value_r[W-2:0], ^(value_r & TAPS)};
        end else begin
            value_nxt_s = value_r;
        end
    end

    // Shift register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_r <= RESET_VAL;
        end else begin
            value_r <= value_nxt_s;
        end
    end

    assign value_o = value_r;

endmodule

// File: rtl/spike_encoder.sv
// Rate-coded spike encoder: loads one intensity per channel over valid/ready,
// then emits WINDOW_LEN timesteps where channel k fires when intensity[k] >= rotl(lfsr, k).
module spike_encoder #(
    parameter int         NUM_CHANNELS = 8,
    parameter int         WIDTH_P      = snn_pkg::WIDTH_P,
    parameter int         WINDOW_LEN   = 255,
    parameter logic [7:0] SEED         = 8'hA5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [WIDTH_P-1:0]      data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    abort_i,
    output logic [NUM_CHANNELS-1:0] spike_o,
    output logic                    spike_valid_o,
    output logic                    frame_done_o,
    output logic [15:0]             step_o
);

    localparam int              CH_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NUM_CHANNELS - 1);
    localparam logic [15:0]     STEP_LAST = 16'(WINDOW_LEN - 1);

    snn_pkg::enc_state_e state_r;
    snn_pkg::enc_state_e state_nxt_s;
    logic [CH_W-1:0]     ch_idx_r;
    logic [CH_W-1:0]     ch_idx_nxt_s;
    logic [15:0]         step_r;
    logic [15:0]         step_nxt_s;
    logic [WIDTH_P-1:0]  intensity_r [NUM_CHANNELS];

    logic                beat_s;
    logic                lfsr_load_s;
    logic                lfsr_en_s;
    logic [7:0]          lfsr_s;
    logic                run_s;
    logic                last_step_s;
    logic [NUM_CHANNELS-1:0] spike_s;

    assign run_s       = (state_r == snn_pkg::ST_RUN);
    assign last_step_s = (step_r == STEP_LAST);

    lfsr_prng #(
        .W         (snn_pkg::LFSR_W),
        .TAPS      (snn_pkg::LFSR_TAPS),
        .RESET_VAL (SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (lfsr_load_s),
        .seed_i  (SEED),
        .en_i    (lfsr_en_s),
        .value_o (lfsr_s)
    );

    // Next-state, beat acceptance and LFSR control; abort overrides everything
    always_comb begin
        state_nxt_s  = state_r;
        ch_idx_nxt_s = ch_idx_r;
        step_nxt_s   = step_r;
        beat_s       = 1'b0;
        lfsr_load_s  = 1'b0;
        lfsr_en_s    = 1'b0;
        if (abort_i) begin
            state_nxt_s  = snn_pkg::ST_LOAD;
            ch_idx_nxt_s = {CH_W{1'b0}};
            step_nxt_s   = 16'd0;
            lfsr_load_s  = 1'b1;
        end else begin
            case (state_r)
                snn_pkg::ST_LOAD: begin
                    if (valid_i) begin
                        beat_s = 1'b1;
                        if (ch_idx_r == CH_LAST) begin
                            state_nxt_s  = snn_pkg::ST_RUN;
                            ch_idx_nxt_s = {CH_W{1'b0}};
                            step_nxt_s   = 16'd0;
                            lfsr_load_s  = 1'b1;
                        end else begin
                            ch_idx_nxt_s = ch_idx_r + CH_W'(1);
                        end
                    end else begin
                        beat_s = 1'b0;
                    end
                end
                snn_pkg::ST_RUN: begin
                    lfsr_en_s = 1'b1;
                    if (last_step_s) begin
                        state_nxt_s = snn_pkg::ST_LOAD;
                        step_nxt_s  = 16'd0;
                    end else begin
                        step_nxt_s = step_r + 16'd1;
                    end
                end
                default: begin
                    state_nxt_s  = snn_pkg::ST_LOAD;
                    ch_idx_nxt_s = {CH_W{1'b0}};
                    step_nxt_s   = 16'd0;
                    lfsr_load_s  = 1'b1;
                end
            endcase
        end
    end

    // Control registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= snn_pkg::ST_LOAD;
            ch_idx_r <= {CH_W{1'b0}};
            step_r   <= 16'd0;
        end else begin
            state_r  <= state_nxt_s;
            ch_idx_r <= ch_idx_nxt_s;
            step_r   <= step_nxt_s;
        end
    end

    // Intensity store; only written by accepted beats, so values survive aborts
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                intensity_r[i] <= {WIDTH_P{1'b0}};
            end
        end else if (beat_s) begin
            intensity_r[ch_idx_r] <= data_i;
        end
    end

    // Per-channel comparators against a channel-specific rotation of the shared LFSR
    always_comb begin
        spike_s = {NUM_CHANNELS{1'b0}};
        if (run_s) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                spike_s[k] = (intensity_r[k] >= snn_pkg::rotl8(lfsr_s, 3'(k % 8)));
            end
        end else begin
            spike_s = {NUM_CHANNELS{1'b0}};
        end
    end

    assign ready_o       = (state_r == snn_pkg::ST_LOAD);
    assign spike_o       = spike_s;
    assign spike_valid_o = run_s;
    assign frame_done_o  = run_s & last_step_s;
    assign step_o        = run_s ? step_r : 16'd0;

endmodule

// File: tb/tb_spike_encoder.sv
// Self-checking bench for spike_encoder: table-driven frames with a timestep scoreboard,
// plus hand-written abort, async-reset and single-step-window sequences.
module tb_spike_encoder;

    typedef struct {
        logic [7:0] spike;
        logic [15:0] step;
        logic        done;
    } exp_t;

    typedef struct {
        logic [7:0] inten [8];
        int         exp_cnt [8];
    } row_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic        abort_i;
    logic [7:0]  spike_o;
    logic        spike_valid_o;
    logic        frame_done_o;
    logic [15:0] step_o;

    logic [7:0]  w1_data;
    logic        w1_valid;
    logic        w1_ready;
    logic        w1_abort;
    logic [7:0]  w1_spike;
    logic        w1_spike_valid;
    logic        w1_done;
    logic [15:0] w1_step;

    int   n_tests;
    int   n_fail;
    int   cnt [8];
    exp_t sb_q [$];
    row_t tbl [4];

    spike_encoder #(.NUM_CHANNELS(8), .WIDTH_P(8), .WINDOW_LEN(255), .SEED(8'hA5)) dut (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .abort_i(abort_i), .spike_o(spike_o), .spike_valid_o(spike_valid_o),
        .frame_done_o(frame_done_o), .step_o(step_o)
    );

    spike_encoder #(.NUM_CHANNELS(8), .WIDTH_P(8), .WINDOW_LEN(1), .SEED(8'hA5)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(w1_data), .valid_i(w1_valid), .ready_o(w1_ready),
        .abort_i(w1_abort), .spike_o(w1_spike), .spike_valid_o(w1_spike_valid),
        .frame_done_o(w1_done), .step_o(w1_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [7:0] m_rot(input logic [7:0] l, input int k);
        logic [7:0] r;
        r = l;
        for (int j = 0; j < k; j++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic push_frame(input logic [7:0] v [8]);
        logic [7:0] l;
        exp_t e;
        l = 8'hA5;
        for (int s = 0; s < 255; s++) begin
            for (int k = 0; k < 8; k++) e.spike[k] = (v[k] >= m_rot(l, k));
            e.step = 16'(s);
            e.done = (s == 254);
            sb_q.push_back(e);
            l = m_next(l);
        end
    endtask

    // Scoreboard: every valid timestep must match the next expected record
    always @(negedge clk) begin
        if (rst_n && spike_valid_o) begin
            if (sb_q.size() == 0) begin
                check("unexpected_timestep", {15'd0, step_o, 1'b1}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("timestep", {7'd0, spike_o, step_o, frame_done_o}, {7'd0, e.spike, e.step, e.done});
                for (int k = 0; k < 8; k++) cnt[k] += int'(spike_o[k]);
            end
        end
    end

    task automatic load_frame(input logic [7:0] v [8]);
        int bad_rdy;
        int bad_run;
        bad_rdy = 0;
        bad_run = 0;
        for (int i = 0; i < 8; i++) begin
            if (ready_o !== 1'b1) bad_rdy++;
            if (spike_valid_o !== 1'b0) bad_run++;
            data_i  = v[i];
            valid_i = 1'b1;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        check("ready_during_load", bad_rdy, 0);
        check("no_run_during_load", bad_run, 0);
        for (int k = 0; k < 8; k++) cnt[k] = 0;
        push_frame(v);
    endtask

    task automatic wait_frame(input bit jam);
        int bad;
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            if (jam) begin
                valid_i = 1'b1;
                data_i  = 8'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
            if (sb_q.size() == 0) break;
            if (ready_o !== 1'b0) bad++;
        end
        valid_i = 1'b0;
        check("frame_complete", sb_q.size(), 0);
        check("ready_after_frame", {31'd0, ready_o}, 32'd1);
        if (jam) check("ready_low_in_run", bad, 0);
        sb_q.delete();
    endtask

    task automatic check_counts(input string name, input int exp [8]);
        for (int k = 0; k < 8; k++) check(name, cnt[k], exp[k]);
    endtask

    initial begin
        logic [7:0] a5 [8];
        int         a5_cnt [8];
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        data_i   = 8'h00;
        valid_i  = 1'b0;
        abort_i  = 1'b0;
        w1_data  = 8'h00;
        w1_valid = 1'b0;
        w1_abort = 1'b0;
        for (int k = 0; k < 8; k++) cnt[k] = 0;

        tbl[0].inten = '{8'd0, 8'd255, 8'd128, 8'd1, 8'd64, 8'd200, 8'd2, 8'd254};
        tbl[0].exp_cnt = '{0, 255, 128, 1, 64, 200, 2, 254};
        tbl[1].inten = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        tbl[1].exp_cnt = '{255, 255, 255, 255, 255, 255, 255, 255};
        tbl[2].inten = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        tbl[2].exp_cnt = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].inten = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        tbl[3].exp_cnt = '{10, 20, 30, 40, 50, 60, 70, 80};
        a5     = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        a5_cnt = '{165, 165, 165, 165, 165, 165, 165, 165};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset: LOAD, ready, no spikes
        for (int i = 0; i < 5; i++) begin
            repeat (4) @(posedge clk);
            #1;
            check("idle", {5'd0, ready_o, spike_o, spike_valid_o, frame_done_o, step_o},
                  {5'd0, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000});
        end

        // Uniform A5 frame: first two timesteps by hand, valid held high during RUN
        load_frame(a5);
        check("a5_ch0_first", {31'd0, spike_o[0]}, 32'd1);
        check("a5_step0", spike_o, 8'h5F);
        @(posedge clk); #1;
        check("a5_step1", spike_o, 8'hFF);
        check("lfsr_step1", dut.u_lfsr.value_o, 8'h4A);
        wait_frame(1'b1);
        check_counts("a5_count", a5_cnt);

        // Table of frames; row 0 also proves the post-jam frame starts at channel 0
        for (int r = 0; r < 4; r++) begin
            load_frame(tbl[r].inten);
            wait_frame(1'b0);
            check_counts("row_count", tbl[r].exp_cnt);
        end

        // Abort at step 10
        load_frame(tbl[0].inten);
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("step_before_abort", step_o, 16'd10);
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        check("abort_idle", {5'd0, ready_o, spike_o, spike_valid_o, frame_done_o, step_o},
              {5'd0, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000});
        sb_q.delete();
        // A beat coincident with abort must be dropped
        abort_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'h77;
        @(posedge clk); #1;
        abort_i = 1'b0;
        valid_i = 1'b0;
        load_frame(tbl[0].inten);
        wait_frame(1'b0);
        check_counts("reload_count", tbl[0].exp_cnt);

        // Asynchronous reset after 3 of 8 beats
        for (int i = 0; i < 3; i++) begin
            data_i  = 8'hEE;
            valid_i = 1'b1;
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        valid_i = 1'b0;
        #1;
        check("async_reset", {5'd0, ready_o, spike_o, spike_valid_o, frame_done_o, step_o},
              {5'd0, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000});
        @(posedge clk); #1;
        rst_n = 1'b1;
        load_frame(tbl[3].inten);
        wait_frame(1'b0);
        check_counts("post_reset_count", tbl[3].exp_cnt);

        // WINDOW_LEN=1: exactly one timestep, flagged as frame end
        for (int i = 0; i < 8; i++) begin
            w1_data  = (i == 0) ? 8'h00 : 8'hFF;
            w1_valid = 1'b1;
            @(posedge clk); #1;
        end
        w1_valid = 1'b0;
        check("w1_single_step", {6'd0, w1_ready, w1_spike, w1_spike_valid, w1_done, w1_step},
              {6'd0, 1'b0, 8'hFE, 1'b1, 1'b1, 16'h0000});
        @(posedge clk); #1;
        check("w1_back_to_load", {6'd0, w1_ready, w1_spike, w1_spike_valid, w1_done, w1_step},
              {6'd0, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_encoder.md
Name: spike_encoder

Overview:
Rate-coded spike encoder. It is the transmit end of the spike interface whose receive end is the spike counter readout. It accepts one frame of NUM_CHANNELS intensities over a valid/ready handshake. It then drives a NUM_CHANNELS-wide spike vector for WINDOW_LEN timesteps, and each channel fires with probability intensity/255. The spike vector feeds the input-layer LIF neurons, replacing raw ui_in bits.

Parameters:
- NUM_CHANNELS, 8, number of input channels / spike lanes.
- WIDTH_P, 8, intensity width; the encoder is defined only for 8.
- WINDOW_LEN, 255, timesteps per frame; legal range 1..65535.
- SEED, 8'hA5, LFSR seed loaded at every frame start; must be nonzero.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- data_i  in  WIDTH_P  intensity beat.
- valid_i  in  1  data_i valid.
- ready_o  out  1  encoder accepts a beat this cycle.
- abort_i  in  1  synchronous frame abort.
- spike_o  out  NUM_CHANNELS  spike vector, one bit per channel.
- spike_valid_o  out  1  spike_o is a valid timestep.
- frame_done_o  out  1  high on the final timestep of a frame.
- step_o  out  16  current timestep index.

Behaviour:
- Interface (already decided): one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset state: state=LOAD, ch_idx=0, step=0, lfsr=SEED, all intensity registers = 0.
- Output values in reset: ready_o=1, spike_o=0, spike_valid_o=0, frame_done_o=0, step_o=0.
- States: LOAD and RUN.
- LOAD:
  - ready_o=1.
  - A beat transfers when valid_i&&ready_o, and is written to intensity[ch_idx]. Beat 0 goes to channel 0.
  - ch_idx increments per beat.
  - On the beat where ch_idx==NUM_CHANNELS-1: next state RUN, ch_idx<=0, step<=0, lfsr<=SEED.
- RUN:
  - ready_o=0; valid_i is ignored and no data is consumed.
  - Each cycle is one timestep: spike_valid_o=1, step_o=step.
  - spike_o[k] = (intensity[k] >= rand_k), where rand_k = lfsr rotated left by (k mod 8) bits.
  - spike_o is combinational from registers only, so the first RUN cycle uses lfsr=SEED.
  - lfsr advances once per RUN cycle.
  - frame_done_o=1 when step==WINDOW_LEN-1. On that cycle the next state is LOAD; otherwise step increments.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Period 255, values 1..255, never 0.
- Boundary behaviour:
  - Intensity 0 never spikes; intensity 255 always spikes.
  - With WINDOW_LEN=255 the LFSR visits every value 1..255 exactly once. The per-channel spike count per frame therefore equals the intensity exactly.
  - WINDOW_LEN=1: a single RUN cycle with frame_done_o=1.
- Outside RUN: spike_o=0, spike_valid_o=0, step_o=0.
- abort_i:
  - Highest priority in either state. Next state LOAD, ch_idx<=0, step<=0, lfsr<=SEED.
  - A beat presented in the same cycle is not accepted, even though ready_o may be 1 in LOAD.
  - Intensity registers are retained until overwritten.
- Reset mid-operation: asynchronous return to the reset state; partial frames are discarded.
- Intensity registers hold their values between frames; a new frame overwrites all channels.

Decomposition:
- Shared package/include snn_pkg, holding:
  - WIDTH_P
  - LFSR width and tap constants
  - encoder state encoding (LOAD=1'b0, RUN=1'b1)
- One sub-module, lfsr_prng:
  - Ports: clk_i, rst_ni, load_i, seed_i, en_i, value_o.
  - Reusable by the weights generator.
- Rotation and comparators stay inline in spike_encoder.

Test Plan:
1. Reset, then release with no stimulus -> ready_o=1, spike_o=8'h00, spike_valid_o=0, step_o=0, held indefinitely.
2. Load {0,255,128,1,64,200,2,254} with WINDOW_LEN=255 and count spikes per channel over the frame -> counts exactly {0,255,128,1,64,200,2,254}; frame_done_o high only at step_o=254; ready_o=1 on the next cycle.
3. Load all channels 8'hA5, SEED=8'hA5, check first RUN cycle -> spike_o[0]=1. spike_o[k] matches the golden model (8'hA5 >= rotl(8'hA5,k)); lfsr value on the second cycle = 8'h4A.
4. Hold valid_i=1 with changing data_i through an entire RUN -> ready_o=0 throughout; intensities unchanged; next frame's first beat lands in channel 0.
5. Assert abort_i at step_o=10 of RUN -> next cycle spike_valid_o=0, spike_o=0, ready_o=1, step_o=0. A reload of the same data reproduces the identical spike sequence (determinism).
6. Assert rst_ni low asynchronously after 3 of 8 beats, then release and send 8 beats -> the first post-reset beat is stored in channel 0; RUN starts only after all 8 new beats.
